bitwise_frame_reducer: RTL and testbench

//   Parametrised, sequential successor to the fixed 16-bit bitwise gate: folds a frame of
//   LEN words, one word per accepted input beat, into a single WIDTH-bit result using a

---
 rtl/bitwise_frame_reducer_if.sv | 37 +++
 rtl/bitwise_frame_reducer.sv | 124 ++++++++++++
 tb/tb_bitwise_frame_reducer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_frame_reducer_if.sv
// Stream bus for the bitwise frame reducer: frame control, input word
// stream and result stream grouped together.
//
// Handshake rule for both streams: a transfer happens on the rising clock
// edge where valid and ready are both 1. The sender keeps valid and data
// stable until that edge. The receiver may raise or lower ready at any time.
// Valid does not depend on ready.
interface bitwise_frame_reducer_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
);
    // Frame control
    logic             start;
    logic [1:0]       mode;
    logic [LEN_W-1:0] len;
    logic             busy;
    // Input word stream
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    // Result stream
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Producer/consumer side
    modport master (
        output start, mode, len, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data
    );

    // Reducer side
    modport slave (
        input  start, mode, len, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bitwise_frame_reducer.sv
// Bitwise frame reducer. It folds a frame of len words into one WIDTH-bit
// result using OR, AND, XOR or NOR. One word is accepted per cycle, and only
// one frame is in flight at a time. All outputs come straight from registers.
module bitwise_frame_reducer #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic                        clock,
    input  logic                        reset_n,
    bitwise_frame_reducer_if.slave      bus,
    output logic [1:0]                  dbg_state_o
);
    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [LEN_W-1:0] rem_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] out_data_q;
    logic             busy_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] ident;
    logic             beat;

    // AND starts from all-ones. OR, XOR and NOR start from zero.
    assign ident = (bus.mode == MODE_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // A beat is accepted only when the reducer offers ready. This keeps an
    // unaccepted in_data out of the accumulator.
    assign beat = bus.in_valid & in_ready_q;

    // Next accumulator value if the current input word is folded in.
    always_comb begin
        acc_d = acc_q;
        case (mode_q)
            MODE_OR,
            MODE_NOR: acc_d = acc_q | bus.in_data;
            MODE_AND: acc_d = acc_q & bus.in_data;
            MODE_XOR: acc_d = acc_q ^ bus.in_data;
            default:  acc_d = acc_q;
        endcase
    end

    // Frame FSM with registered outputs: IDLE -> ACC -> DONE -> IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            mode_q      <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        acc_q  <= ident;
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            state_q    <= ST_ACC;
                            rem_q      <= bus.len;
                            in_ready_q <= 1'b1;
                        end else begin
                            // Empty frame: the result is the identity,
                            // inverted for NOR.
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= (bus.mode == MODE_NOR) ? ~ident : ident;
                        end
                    end
                end
                ST_ACC: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        if (rem_q != '0) begin
                            rem_q <= rem_q - 1'b1;
                        end
                        // The last beat publishes the result on the same edge.
                        if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= (mode_q == MODE_NOR) ? ~acc_d : acc_d;
                        end
                    end
                end
                ST_DONE: begin
                    // out_data_q keeps its value after the handshake.
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_bitwise_frame_reducer.sv
// Testbench for bitwise_frame_reducer (WIDTH=16, LEN_W=5). Each expected
// result is pushed to exp_q when its frame is driven. The result monitor
// pops and compares it on the output handshake.
module tb_bitwise_frame_reducer;
    localparam int WIDTH = 16;
    localparam int LEN_W = 5;
    localparam logic [1:0] M_OR  = 2'b00;
    localparam logic [1:0] M_AND = 2'b01;
    localparam logic [1:0] M_XOR = 2'b10;
    localparam logic [1:0] M_NOR = 2'b11;

    logic             clk;
    logic             rst_n;
    logic [1:0]       dbg_state;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] frame_w[$];
    int               total;
    int               bad;

    bitwise_frame_reducer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    bitwise_frame_reducer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: compare each result on its handshake, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 32'(bus.out_data), 32'hDEAD_0000);
            else check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [1:0] m);
        logic [WIDTH-1:0] a;
        a = (m == M_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        foreach (frame_w[i]) begin
            case (m)
                M_AND:   a = a & frame_w[i];
                M_XOR:   a = a ^ frame_w[i];
                default: a = a | frame_w[i];
            endcase
        end
        if (m == M_NOR) a = ~a;
        return a;
    endfunction

    // Driver tasks
    task automatic start_frame(input logic [1:0] m, input logic [LEN_W-1:0] l);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.mode  = 2'($urandom_range(0, 3));
        bus.len   = LEN_W'($urandom_range(0, 31));
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input int gap);
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.in_data = WIDTH'($urandom);
            check("gap_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        check("early_out_valid", 32'(bus.out_valid), 32'd0);
        check("beat_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = WIDTH'($urandom);
    endtask

    task automatic recv(input int hold);
        int n;
        logic [WIDTH-1:0] held;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("wait_out_valid", 32'(bus.out_valid), 32'd1);
        if (bus.out_valid) begin
            held = bus.out_data;
            bus.start = (hold > 0);
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(held));
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("hold_state", 32'(dbg_state), 32'd2);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            bus.start     = 1'b0;
            check("post_valid", 32'(bus.out_valid), 32'd0);
            check("post_state", 32'(dbg_state), 32'd0);
            check("post_busy", 32'(bus.busy), 32'd0);
            check("post_data_kept", 32'(bus.out_data), 32'(held));
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input int gap, input int hold,
                             input logic [WIDTH-1:0] exp);
        int n;
        n = frame_w.size();
        exp_q.push_back(exp);
        start_frame(m, LEN_W'(n));
        check("busy_after_start", 32'(bus.busy), 32'd1);
        if (n == 0) begin
            check("len0_latency", 32'(bus.out_valid), 32'd1);
        end else begin
            foreach (frame_w[i]) send_word(frame_w[i], gap);
            check("last_beat_latency", 32'(bus.out_valid), 32'd1);
            check("done_in_ready", 32'(bus.in_ready), 32'd0);
        end
        recv(hold);
    endtask

    // Main sequence
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.mode = '0;
        bus.len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a frame discards the partial result
        start_frame(M_OR, 5'd3);
        send_word(16'h00F0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = WIDTH'($urandom);
            tick();
            check("after_rst_idle", 32'(dbg_state), 32'd0);
            check("after_rst_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;

        // OR back-to-back beats
        frame_w = '{16'h0001, 16'h0F00, 16'h8000};
        run_frame(M_OR, 0, 0, 16'h8F01);
        // AND with two-cycle gaps between beats
        frame_w = '{16'hFF0F, 16'h0FFF};
        run_frame(M_AND, 2, 0, 16'h0F0F);
        // XOR
        frame_w = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0001};
        run_frame(M_XOR, 0, 0, 16'h0001);
        // NOR, then five cycles of back-pressure with start held high
        frame_w = '{16'h00F0, 16'h0F00};
        run_frame(M_NOR, 0, 5, 16'hF00F);
        // Empty frames
        frame_w = {};
        run_frame(M_AND, 0, 0, 16'hFFFF);
        run_frame(M_OR, 0, 0, 16'h0000);
        run_frame(M_NOR, 0, 1, 16'hFFFF);
        // Maximum length frame: 31 one-hot beats
        frame_w = {};
        for (int i = 0; i < 31; i++) frame_w.push_back(WIDTH'(1) << (i % 16));
        run_frame(M_OR, 0, 0, 16'hFFFF);

        // Random frames checked against the model
        for (int f = 0; f < 20; f++) begin
            logic [1:0] m;
            int n;
            m = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 6);
            frame_w = {};
            for (int i = 0; i < n; i++) frame_w.push_back(WIDTH'($urandom));
            run_frame(m, $urandom_range(0, 2), $urandom_range(0, 3), model(m));
        end

        tick();
        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
